// File: rtl/rc4_key_schedule_if.sv
// Bus between the RC4 key scheduler and the rest of the pipeline: control, key,
// and the single read/write port onto the shared S working memory.
interface rc4_key_schedule_if #(
    parameter int KEY_BYTES  = 3,
    parameter int DATA_WIDTH = 8
);
    logic                    start;
    logic [8*KEY_BYTES-1:0]  secret_key;
    logic [DATA_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_wrdata;
    logic                    mem_wren;
    logic [DATA_WIDTH-1:0]   mem_rddata;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, secret_key, mem_rddata,
        output mem_address, mem_wrdata, mem_wren, busy, done
    );

    modport slave (
        output start, secret_key, mem_rddata,
        input  mem_address, mem_wrdata, mem_wren, busy, done
    );
endinterface

// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling engine: writes the identity permutation into S, then runs
// the key-driven swap loop through one synchronous-read memory port.
module rc4_key_schedule #(
    parameter int KEY_BYTES  = 3,
    parameter int S_DEP      = 256,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    rc4_key_schedule_if.master bus
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [DATA_WIDTH-1:0] LAST_I = DATA_WIDTH'(S_DEP - 1);
    localparam logic [KW-1:0]         LAST_K = KW'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT   = 4'd1,
        RD_I   = 4'd2,
        WAIT_I = 4'd3,
        CAP_I  = 4'd4,
        RD_J   = 4'd5,
        WAIT_J = 4'd6,
        CAP_J  = 4'd7,
        WR_J   = 4'd8,
        WR_I   = 4'd9,
        DONE   = 4'd10
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] i_q, i_d;
    logic [DATA_WIDTH-1:0] j_q, j_d;
    logic [DATA_WIDTH-1:0] si_q, si_d;
    logic [DATA_WIDTH-1:0] sj_q, sj_d;
    logic [KW-1:0]         k_q, k_d;

    logic [DATA_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wrdata;
    logic                  mem_wren;
    logic                  busy;
    logic                  done;

    // Byte 0 of the key sits in the most significant byte lane.
    logic [7:0] key_bytes [KEY_BYTES];
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key
        assign key_bytes[gi] = bus.secret_key[8*(KEY_BYTES-1-gi) +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        k_d         = k_q;
        mem_address = '0;
        mem_wrdata  = '0;
        mem_wren    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = INIT;
                    i_d     = '0;
                end
            end
            INIT: begin
                busy        = 1'b1;
                mem_address = i_q;
                mem_wrdata  = i_q;
                mem_wren    = 1'b1;
                i_d         = i_q + DATA_WIDTH'(1);
                if (i_q == LAST_I) begin
                    state_d = RD_I;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            RD_I: begin
                busy        = 1'b1;
                mem_address = i_q;
                state_d     = WAIT_I;
            end
            WAIT_I: begin
                busy        = 1'b1;
                mem_address = i_q;
                state_d     = CAP_I;
            end
            // Read data is taken two edges after the address first appears,
            // so a RAM with a registered output still delivers in time.
            CAP_I: begin
                busy        = 1'b1;
                mem_address = i_q;
                si_d        = bus.mem_rddata;
                j_d         = j_q + bus.mem_rddata + DATA_WIDTH'(key_bytes[k_q]);
                state_d     = RD_J;
            end
            RD_J: begin
                busy        = 1'b1;
                mem_address = j_q;
                state_d     = WAIT_J;
            end
            WAIT_J: begin
                busy        = 1'b1;
                mem_address = j_q;
                state_d     = CAP_J;
            end
            CAP_J: begin
                busy        = 1'b1;
                mem_address = j_q;
                sj_d        = bus.mem_rddata;
                state_d     = WR_J;
            end
            WR_J: begin
                busy        = 1'b1;
                mem_address = j_q;
                mem_wrdata  = si_q;
                mem_wren    = 1'b1;
                state_d     = WR_I;
            end
            // When i == j both writes carry the same value, leaving S intact.
            WR_I: begin
                busy        = 1'b1;
                mem_address = i_q;
                mem_wrdata  = sj_q;
                mem_wren    = 1'b1;
                i_d         = i_q + DATA_WIDTH'(1);
                k_d         = (k_q == LAST_K) ? '0 : k_q + KW'(1);
                state_d     = (i_q == LAST_I) ? DONE : RD_I;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    state_d = INIT;
                    i_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_address = mem_address;
    assign bus.mem_wrdata  = mem_wrdata;
    assign bus.mem_wren    = mem_wren;
    assign bus.busy        = busy;
    assign bus.done        = done;
endmodule
